// File: rtl/mul_div_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_pkg
//  Description : Shared opcodes, FSM states and result-sign rules for the
//                iterative multiply/divide unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_SIGN = 2'd2
  } state_e;

  // Operand magnitudes are only taken for the signed variants.
  function automatic logic is_signed_op(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  // Result negation flags {hi_neg, lo_neg}. A product negates as a whole
  // (both bits equal); a quotient follows the XOR of operand signs while the
  // remainder follows the dividend so that division truncates toward zero.
  function automatic logic [1:0] res_neg(input op_e op, input logic s1,
                                         input logic s2);
    logic [1:0] r;
    r = 2'b00;
    if (op == OP_MULT)     r = {2{s1 ^ s2}};
    else if (op == OP_DIV) r = {s1, s1 ^ s2};
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mul_div_unit_if
//  Description : Request/response bundle between the execute-stage control
//                and the multiply/divide unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mul_div_unit_if #(
  parameter int WIDTH = 32
) ();
  logic             i_start;
  logic [2:0]       i_op;
  logic [WIDTH-1:0] i_op1;
  logic [WIDTH-1:0] i_op2;
  logic [WIDTH-1:0] o_hi;
  logic [WIDTH-1:0] o_lo;
  logic             o_busy;
  logic             o_done;
  logic             o_div0;

  modport master (
    output i_start, i_op, i_op1, i_op2,
    input  o_hi, o_lo, o_busy, o_done, o_div0
  );

  modport slave (
    input  i_start, i_op, i_op1, i_op2,
    output o_hi, o_lo, o_busy, o_done, o_div0
  );
endinterface
`default_nettype wire

// File: rtl/mul_div_unit_cond_neg.sv
`default_nettype none
// ============================================================================
//  Module      : cond_neg
//  Description : Two's-complement negate when i_neg is set, else pass-through.
//  Revision    : 1.0 - initial release
// ============================================================================
module cond_neg #(
  parameter int W = 32
) (
  input  wire logic [W-1:0] i_a,
  input  wire logic         i_neg,
  output logic      [W-1:0] o_y
);
  // Negation of the most negative value wraps to itself, which is what the
  // MIN / -1 and |MIN| cases rely on.
  assign o_y = i_neg ? (~i_a + W'(1)) : i_a;
endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mul_div_unit
//  Description : Iterative multiply/divide unit with architectural HI/LO.
//                Radix-2 shift-add multiply and restoring divide, one bit
//                per cycle, followed by a sign fix-up cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input wire logic        i_clk,
  input wire logic        i_rst_n,
  mul_div_unit_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;  // product high half / partial remainder
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;  // multiplier / dividend -> quotient
  logic [WIDTH-1:0]   mag_q, mag_d;        // multiplicand / divisor magnitude
  logic [1:0]         neg_q, neg_d;        // {hi_neg, lo_neg}
  logic               is_div_q, is_div_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               div0_q, div0_d;

  op_e                op_w;
  logic               sgn_w;
  logic [WIDTH-1:0]   mag1_w, mag2_w;
  logic [WIDTH:0]     sum_w, rem_sh_w, diff_w;
  logic [2*WIDTH-1:0] prod_fix_w;
  logic [WIDTH-1:0]   quo_fix_w, rem_fix_w;

  assign op_w  = op_e'(bus.i_op);
  assign sgn_w = is_signed_op(op_w);

  cond_neg #(.W(WIDTH)) u_mag1 (
    .i_a(bus.i_op1), .i_neg(sgn_w & bus.i_op1[WIDTH-1]), .o_y(mag1_w));
  cond_neg #(.W(WIDTH)) u_mag2 (
    .i_a(bus.i_op2), .i_neg(sgn_w & bus.i_op2[WIDTH-1]), .o_y(mag2_w));
  cond_neg #(.W(2*WIDTH)) u_prod (
    .i_a({acc_hi_q, acc_lo_q}), .i_neg(neg_q[0]), .o_y(prod_fix_w));
  cond_neg #(.W(WIDTH)) u_quo (
    .i_a(acc_lo_q), .i_neg(neg_q[0]), .o_y(quo_fix_w));
  cond_neg #(.W(WIDTH)) u_rem (
    .i_a(acc_hi_q), .i_neg(neg_q[1]), .o_y(rem_fix_w));

  // Datapath step values: shift-add sum and restoring-divide trial subtract.
  always_comb begin
    sum_w    = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_q} : '0);
    rem_sh_w = {acc_hi_q, acc_lo_q[WIDTH-1]};
    diff_w   = rem_sh_w - {1'b0, mag_q};
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    mag_d    = mag_q;
    neg_d    = neg_q;
    is_div_d = is_div_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    div0_d   = div0_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          case (op_w)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              div0_d   = 1'b0;
              neg_d    = res_neg(op_w, bus.i_op1[WIDTH-1], bus.i_op2[WIDTH-1]);
              is_div_d = bus.i_op[1];
              acc_hi_d = '0;
              acc_lo_d = bus.i_op[1] ? mag1_w : mag2_w;
              mag_d    = bus.i_op[1] ? mag2_w : mag1_w;
              cnt_d    = CNT_W'(WIDTH);
              dz_d     = bus.i_op[1] && (bus.i_op2 == '0);
              state_d  = (bus.i_op[1] && (bus.i_op2 == '0)) ? ST_SIGN : ST_CALC;
            end
            OP_MTHI: begin
              hi_d   = bus.i_op1;
              done_d = 1'b1;
              div0_d = 1'b0;
            end
            OP_MTLO: begin
              lo_d   = bus.i_op1;
              done_d = 1'b1;
              div0_d = 1'b0;
            end
            default: ;
          endcase
        end
      end
      ST_CALC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (is_div_q) begin
          if (!diff_w[WIDTH]) begin
            acc_hi_d = diff_w[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi_d = rem_sh_w[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_hi_d = sum_w[WIDTH:1];
          acc_lo_d = {sum_w[0], acc_lo_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_W'(1)) state_d = ST_SIGN;
      end
      ST_SIGN: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (dz_q) begin
          div0_d = 1'b1;
        end else if (is_div_q) begin
          hi_d = rem_fix_w;
          lo_d = quo_fix_w;
        end else begin
          {hi_d, lo_d} = prod_fix_w;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      mag_q    <= '0;
      neg_q    <= '0;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      mag_q    <= mag_d;
      neg_q    <= neg_d;
      is_div_q <= is_div_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      div0_q   <= div0_d;
    end
  end

  assign bus.o_hi   = hi_q;
  assign bus.o_lo   = lo_q;
  assign bus.o_busy = (state_q != ST_IDLE);
  assign bus.o_done = done_q;
  assign bus.o_div0 = div0_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_div_unit
//  Description : Directed and small random checks of mul_div_unit at WIDTH=32.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;
  import mdu_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_div_unit_if #(.WIDTH(W)) bus ();
  mul_div_unit #(.WIDTH(W)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] m;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    m  = '0;
    case (op)
      3'b000: m = sa * sb;
      3'b001: m = {32'b0, a} * {32'b0, b};
      3'b010: begin q = sa / sb; r = sa % sb; m = {r[31:0], q[31:0]}; end
      default: m = {a % b, a / b};
    endcase
    return m;
  endfunction

  // Issue one request, scramble operands after acceptance, wait for o_done.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic busy0);
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_op = op; bus.i_op1 = a; bus.i_op2 = b;
    @(negedge clk);
    bus.i_start = 1'b0; bus.i_op1 = $urandom; bus.i_op2 = $urandom;
    busy0 = bus.o_busy;
    lat = 0;
    while (!bus.o_done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 100) chk("timeout", 64'(lat), 64'(0));
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                     input int elat);
    int   lat;
    logic busy0;
    do_op(op, a, b, lat, busy0);
    chk({tag, "_lat"}, 64'(lat), 64'(elat));
    chk({tag, "_hi"}, 64'(bus.o_hi), 64'(ehi));
    chk({tag, "_lo"}, 64'(bus.o_lo), 64'(elo));
    chk({tag, "_busy0"}, 64'(busy0), 64'(elat > 0));
    chk({tag, "_busy_end"}, 64'(bus.o_busy), 64'(0));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(bus.o_done), 64'(0));
  endtask

  initial begin
    int          lat, n;
    logic        busy0;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [63:0] m;

    bus.i_start = 1'b0; bus.i_op = 3'b110; bus.i_op1 = '0; bus.i_op2 = '0;
    repeat (3) @(negedge clk);
    chk("reset", {bus.o_hi, bus.o_lo}, 64'h0);
    chk("reset_flags", {61'b0, bus.o_busy, bus.o_done, bus.o_div0}, 64'h0);
    rst_n = 1'b1;

    run("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 33);
    run("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33);
    run("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
    run("div_min", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33);
    run("divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33);
    run("mthi", OP_MTHI, 32'd5, 32'd0, 32'd5, 32'd14, 0);
    run("mtlo", OP_MTLO, 32'd6, 32'd0, 32'd5, 32'd6, 0);

    run("div0", OP_DIVU, 32'd100, 32'd0, 32'd5, 32'd6, 1);
    chk("div0_flag", 64'(bus.o_div0), 64'(1));
    do_op(OP_MULTU, 32'd2, 32'd3, lat, busy0);
    chk("div0_clear", 64'(bus.o_div0), 64'(0));
    chk("div0_next_lo", 64'(bus.o_lo), 64'd6);

    // DIV requested while busy must be dropped, not queued.
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_op = OP_MULT; bus.i_op1 = 32'd2; bus.i_op2 = 32'd3;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (9) @(negedge clk);
    bus.i_start = 1'b1; bus.i_op = OP_DIV; bus.i_op1 = 32'd9; bus.i_op2 = 32'd3;
    @(negedge clk);
    bus.i_start = 1'b0;
    lat = 0;
    while (!bus.o_done && lat < 100) begin @(negedge clk); lat++; end
    chk("busy_ign_res", {bus.o_hi, bus.o_lo}, 64'd6);
    n = 0;
    repeat (40) begin @(negedge clk); if (bus.o_done) n++; end
    chk("busy_no_queue", 64'(n), 64'(0));

    run("mtlo_pat", OP_MTLO, 32'hAAAA5555, 32'd0, 32'h0, 32'hAAAA5555, 0);

    // Start held from the SIGN cycle through the done cycle: only the second
    // edge may accept it.
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_op = OP_MULTU; bus.i_op1 = 32'd3; bus.i_op2 = 32'd5;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (32) @(negedge clk);
    bus.i_start = 1'b1; bus.i_op = OP_DIVU; bus.i_op1 = 32'd9; bus.i_op2 = 32'd3;
    @(negedge clk);
    chk("b2b_done", 64'(bus.o_done), 64'(1));
    chk("b2b_first", {bus.o_hi, bus.o_lo}, 64'd15);
    @(negedge clk);
    bus.i_start = 1'b0;
    chk("b2b_accept", {62'b0, bus.o_busy, bus.o_done}, 64'b10);
    lat = 0;
    while (!bus.o_done && lat < 100) begin @(negedge clk); lat++; end
    chk("b2b_lat", 64'(lat), 64'(33));
    chk("b2b_second", {bus.o_hi, bus.o_lo}, 64'd3);

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_op = OP_MULT; bus.i_op1 = 32'd77; bus.i_op2 = 32'd99;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_hilo", {bus.o_hi, bus.o_lo}, 64'h0);
    chk("rst_mid_busy", 64'(bus.o_busy), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run("post_rst", OP_MULT, 32'd12, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFC4, 33);

    // NOP produces no done and leaves HI/LO alone.
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_op = 3'b110; bus.i_op1 = 32'h1234;
    @(negedge clk);
    bus.i_start = 1'b0;
    n = 0;
    repeat (5) begin if (bus.o_done || bus.o_busy) n++; @(negedge clk); end
    chk("nop_quiet", 64'(n), 64'(0));
    chk("nop_hilo", {bus.o_hi, bus.o_lo}, 64'hFFFFFFFF_FFFFFFC4);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if (i % 4 == 1) b = b >> $urandom_range(0, 31);
      if (b == 0) b = 32'd1;
      m = model(op, a, b);
      do_op(op, a, b, lat, busy0);
      chk($sformatf("rnd%0d_op%0d", i, op), {bus.o_hi, bus.o_lo}, m);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
